// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the single-port FIFO controller.
// Grant encoding doubles as the FIFO port-select value.
package fifo_ctrl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic GNT_WR = 1'b0;
  localparam logic GNT_RD = 1'b1;

  localparam int BIT_D_DEF = 32;

endpackage

// File: rtl/fifo_rr_arb.sv
// Two-way write/read arbiter for the shared FIFO RAM port.
// FAIR=1 alternates on contention, FAIR=0 gives write fixed priority.
import fifo_ctrl_pkg::*;

module fifo_rr_arb #(
  parameter int FAIR = 1
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic wr_req_i,
  input  logic rd_req_i,
  output logic wr_gnt_o,
  output logic rd_gnt_o
);

  logic last_q;
  logic last_d;
  logic wr_wins;

  always_comb begin
    wr_wins  = ~rd_req_i
             | (FAIR == 0)
             | (last_q == GNT_RD);
    wr_gnt_o = wr_req_i & wr_wins;
    rd_gnt_o = rd_req_i & ~wr_gnt_o;
    last_d   = last_q;
    if (wr_gnt_o) begin
      last_d = GNT_WR;
    end else if (rd_gnt_o) begin
      last_d = GNT_RD;
    end
  end

  // Starting from READ lets the write side win the first tie.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      last_q <= GNT_RD;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fifo_sp_ctrl.sv
// Controller in front of a single-port-RAM FIFO: arbitrates the shared
// port, owns init/flush, and registers the read side as a stream.
import fifo_ctrl_pkg::*;

module fifo_sp_ctrl #(
  parameter int BIT_D   = BIT_D_DEF,
  parameter int NUM_REG = 6,
  parameter int FAIR    = 1
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             flush_i,
  input  logic             s_valid_i,
  input  logic [BIT_D-1:0] s_data_i,
  output logic             s_ready_o,
  output logic             m_valid_o,
  output logic [BIT_D-1:0] m_data_o,
  input  logic             m_ready_i,
  output logic             f_srst_o,
  output logic             f_wr_o,
  output logic             f_rd_o,
  output logic             f_sel_o,
  output logic [BIT_D-1:0] f_data_o,
  input  logic [BIT_D-1:0] f_data_i,
  input  logic             f_full_i,
  input  logic             f_empty_i
);

  if (NUM_REG < 1) begin : g_chk_depth
    $error("fifo_sp_ctrl: NUM_REG must be at least 1");
  end

  state_e           state_q;
  state_e           state_d;
  logic             m_valid_q;
  logic             m_valid_d;
  logic [BIT_D-1:0] m_data_q;
  logic [BIT_D-1:0] m_data_d;
  logic             rd_infl_q;
  logic             rd_infl_d;

  logic run;
  logic flush_run;
  logic wr_req;
  logic rd_req;
  logic wr_gnt;
  logic rd_gnt;
  logic capture;

  always_comb begin
    run       = (state_q == RUN) & ~flush_i;
    flush_run = (state_q == RUN) & flush_i;
    wr_req    = run & s_valid_i & ~f_full_i;
    rd_req    = run
              & ~f_empty_i
              & ~rd_infl_q
              & (~m_valid_q | m_ready_i);
  end

  fifo_rr_arb #(
    .FAIR(FAIR)
  ) u_arb (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .wr_req_i(wr_req),
    .rd_req_i(rd_req),
    .wr_gnt_o(wr_gnt),
    .rd_gnt_o(rd_gnt)
  );

  // Held low while arst_i is asserted so the FIFO reset is a single
  // clean pulse in the INIT cycle after release.
  always_comb begin
    f_srst_o  = (state_q == INIT) & ~arst_i;
    s_ready_o = wr_gnt;
    f_wr_o    = wr_gnt;
    f_rd_o    = rd_gnt;
    f_sel_o   = rd_gnt ? GNT_RD : GNT_WR;
    f_data_o  = s_data_i;
    m_valid_o = m_valid_q;
    m_data_o  = m_data_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT: state_d = RUN;
      RUN:  state_d = flush_i ? INIT : RUN;
    endcase
  end

  // Flush drops any read still in flight.
  always_comb begin
    capture   = rd_infl_q & ~flush_run;
    rd_infl_d = rd_gnt;
    m_data_d  = capture ? f_data_i : m_data_q;
    m_valid_d = m_valid_q;
    if (flush_run) begin
      m_valid_d = 1'b0;
    end else if (capture) begin
      m_valid_d = 1'b1;
    end else if (m_valid_q & m_ready_i) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= INIT;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      rd_infl_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      rd_infl_q <= rd_infl_d;
    end
  end

endmodule

// File: tb/tb_fifo_sp_ctrl.sv
// Bench for fifo_sp_ctrl with a behavioural single-port FIFO and a
// queue scoreboard checked by an independent output monitor.
module tb_fifo_sp_ctrl;

  logic        clk = 1'b0;
  logic        arst_i;
  logic        flush_i;
  logic        s_valid_i;
  logic [31:0] s_data_i;
  logic        s_ready_o;
  logic        m_valid_o;
  logic [31:0] m_data_o;
  logic        m_ready_i;
  logic        f_srst_o;
  logic        f_wr_o;
  logic        f_rd_o;
  logic        f_sel_o;
  logic [31:0] f_data_o;
  logic [31:0] f_data_i = '0;
  logic        f_full_i;
  logic        f_empty_i;

  int total = 0;
  int bad = 0;
  int pop_cnt = 0;
  logic [31:0] exp_q[$];

  logic [31:0] mem [0:5];
  int cnt = 0;
  int wp = 0;
  int rp = 0;

  always #5 clk = ~clk;

  fifo_sp_ctrl #(
    .BIT_D(32),
    .NUM_REG(6),
    .FAIR(1)
  ) dut (
    .clk_i    (clk),
    .arst_i   (arst_i),
    .flush_i  (flush_i),
    .s_valid_i(s_valid_i),
    .s_data_i (s_data_i),
    .s_ready_o(s_ready_o),
    .m_valid_o(m_valid_o),
    .m_data_o (m_data_o),
    .m_ready_i(m_ready_i),
    .f_srst_o (f_srst_o),
    .f_wr_o   (f_wr_o),
    .f_rd_o   (f_rd_o),
    .f_sel_o  (f_sel_o),
    .f_data_o (f_data_o),
    .f_data_i (f_data_i),
    .f_full_i (f_full_i),
    .f_empty_i(f_empty_i)
  );

  assign f_full_i  = (cnt >= 6);
  assign f_empty_i = (cnt == 0);

  always @(posedge clk) begin
    if (f_srst_o) begin
      cnt <= 0;
      wp  <= 0;
      rp  <= 0;
    end else begin
      if (f_wr_o) begin
        mem[wp] <= f_data_o;
        wp      <= (wp + 1) % 6;
      end
      if (f_rd_o) begin
        f_data_i <= mem[rp];
        rp       <= (rp + 1) % 6;
      end
      cnt <= cnt + (f_wr_o ? 1 : 0) - (f_rd_o ? 1 : 0);
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("wr_rd_excl", {31'd0, f_wr_o & f_rd_o}, 32'd0);
    chk("sel_eq_rd", {31'd0, f_sel_o}, {31'd0, f_rd_o});
    if (f_wr_o) chk("no_wr_full", {31'd0, f_full_i}, 32'd0);
    if (f_rd_o) chk("no_rd_empty", {31'd0, f_empty_i}, 32'd0);
    if (arst_i || flush_i || f_srst_o) begin
      exp_q.delete();
    end else begin
      if (m_valid_o && m_ready_i) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got %0h want none", m_data_o);
        end else begin
          chk("m_data", m_data_o, exp_q.pop_front());
        end
      end
      if (s_valid_i && s_ready_o) exp_q.push_back(s_data_i);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, output bit ok);
    s_valid_i = 1'b1;
    s_data_i  = d;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      ok = s_ready_o;
      tick();
      if (ok) break;
    end
    s_valid_i = 1'b0;
  endtask

  task automatic drain(input int n);
    m_ready_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0 && !m_valid_o) break;
      tick();
    end
    chk("drain_left", exp_q.size(), 32'd0);
    chk("drain_mvalid", {31'd0, m_valid_o}, 32'd0);
    m_ready_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc;
    int base;
    logic [31:0] d;
    arst_i = 1'b1;
    flush_i = 1'b0;
    s_valid_i = 1'b0;
    s_data_i = '0;
    m_ready_i = 1'b0;

    // reset values
    repeat (2) tick();
    #1;
    chk("rst_srst", {31'd0, f_srst_o}, 32'd0);
    chk("rst_sready", {31'd0, s_ready_o}, 32'd0);
    chk("rst_mvalid", {31'd0, m_valid_o}, 32'd0);
    chk("rst_mdata", m_data_o, 32'd0);
    tick();

    // release; INIT cycle then first write 0xA1
    arst_i = 1'b0;
    s_valid_i = 1'b1;
    s_data_i = 32'hA1;
    #1;
    chk("init_srst", {31'd0, f_srst_o}, 32'd1);
    chk("init_sready", {31'd0, s_ready_o}, 32'd0);
    tick();
    #1;
    chk("run_srst", {31'd0, f_srst_o}, 32'd0);
    chk("wr_sready", {31'd0, s_ready_o}, 32'd1);
    chk("wr_strobe", {31'd0, f_wr_o}, 32'd1);
    chk("wr_sel", {31'd0, f_sel_o}, 32'd0);
    tick();
    s_valid_i = 1'b0;
    #1;
    chk("rd_strobe", {31'd0, f_rd_o}, 32'd1);
    chk("rd_sel", {31'd0, f_sel_o}, 32'd1);
    tick();
    #1;
    chk("infl_mvalid", {31'd0, m_valid_o}, 32'd0);
    tick();
    #1;
    chk("lat_mvalid", {31'd0, m_valid_o}, 32'd1);
    chk("lat_mdata", m_data_o, 32'hA1);
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    #1;
    chk("pop_mvalid", {31'd0, m_valid_o}, 32'd0);
    tick();

    // fill: 6 in FIFO plus 1 in output register
    acc = 0;
    for (int k = 1; k <= 8; k++) begin
      d = k;
      send(d, ok);
      if (ok) acc++;
      if (k == 8) chk("full_blocks_8", {31'd0, ok}, 32'd0);
    end
    chk("fill_accepted", acc, 32'd7);
    base = pop_cnt;
    drain(60);
    chk("fill_popped", pop_cnt - base, 32'd7);

    // fair alternation under contention
    send(32'h11, ok);
    send(32'h12, ok);
    send(32'h13, ok);
    s_valid_i = 1'b1;
    s_data_i = 32'h100;
    m_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("fair_rd", {31'd0, f_rd_o}, {31'd0, (i % 2) == 0});
      chk("fair_wr", {31'd0, f_wr_o}, {31'd0, (i % 2) == 1});
      ok = s_ready_o;
      tick();
      if (ok) s_data_i = s_data_i + 1;
    end
    s_valid_i = 1'b0;
    drain(60);

    // flush while a read is in flight
    send(32'h55, ok);
    #1;
    chk("fl_rd_issued", {31'd0, f_rd_o}, 32'd1);
    tick();
    flush_i = 1'b1;
    s_valid_i = 1'b1;
    s_data_i = 32'h66;
    #1;
    chk("fl_no_wr", {31'd0, f_wr_o}, 32'd0);
    chk("fl_no_rd", {31'd0, f_rd_o}, 32'd0);
    chk("fl_sready", {31'd0, s_ready_o}, 32'd0);
    tick();
    flush_i = 1'b0;
    s_valid_i = 1'b0;
    #1;
    chk("fl_srst", {31'd0, f_srst_o}, 32'd1);
    chk("fl_mvalid0", {31'd0, m_valid_o}, 32'd0);
    tick();
    #1;
    chk("fl_srst_end", {31'd0, f_srst_o}, 32'd0);
    chk("fl_mvalid1", {31'd0, m_valid_o}, 32'd0);
    tick();
    #1;
    chk("fl_mvalid2", {31'd0, m_valid_o}, 32'd0);
    tick();

    // async reset mid write burst
    s_valid_i = 1'b1;
    s_data_i = 32'h200;
    repeat (4) tick();
    #1;
    chk("pre_rst_mvalid", {31'd0, m_valid_o}, 32'd1);
    chk("pre_rst_sready", {31'd0, s_ready_o}, 32'd1);
    #1;
    arst_i = 1'b1;
    #1;
    chk("arst_sready", {31'd0, s_ready_o}, 32'd0);
    chk("arst_wr", {31'd0, f_wr_o}, 32'd0);
    chk("arst_rd", {31'd0, f_rd_o}, 32'd0);
    chk("arst_sel", {31'd0, f_sel_o}, 32'd0);
    chk("arst_srst", {31'd0, f_srst_o}, 32'd0);
    chk("arst_mvalid", {31'd0, m_valid_o}, 32'd0);
    chk("arst_mdata", m_data_o, 32'd0);
    s_valid_i = 1'b0;
    repeat (2) tick();
    arst_i = 1'b0;
    #1;
    chk("rearm_srst", {31'd0, f_srst_o}, 32'd1);
    tick();
    #1;
    chk("rearm_srst_end", {31'd0, f_srst_o}, 32'd0);
    base = pop_cnt;
    send(32'h77, ok);
    drain(20);
    chk("post_rst_pop", pop_cnt - base, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
